// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for one data-memory client.
interface dmem_arbiter_if #(
    parameter int unsigned WORD = 64
);

    logic            req;
    logic            we;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
    logic            ack;
    logic            err;
    logic [WORD-1:0] rdata;

    // Client side: issues requests, receives completion.
    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  err,
        input  rdata
    );

    // Arbiter side: samples requests, returns completion.
    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output err,
        output rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and three-cycle access sequencer for the single-port data memory.
// Each access runs IDLE -> ACC -> RESP; m0/m1 alternate when both request continuously.
module dmem_arbiter #(
    parameter int unsigned WORD = 64,
    parameter int unsigned SIZE = 1024
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   m0,
    dmem_arbiter_if.slave   m1,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [WORD-1:0] mem_addr,
    inout  wire  [WORD-1:0] mem_data,
    output logic            busy
);

    localparam int unsigned OFFS = 3;   // log2 of bytes per word

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            grant;

    // Transaction registers latched at acceptance
    logic            prio_q,  prio_d;
    logic            sel_q,   sel_d;
    logic            we_q,    we_d;
    logic            bad_q,   bad_d;
    logic [WORD-1:0] addr_q,  addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;

    // Registered output images
    logic            rd_q,    rd_d;
    logic            wr_q,    wr_d;
    logic            drive_q, drive_d;
    logic [1:0]      ack_q,   ack_d;
    logic [1:0]      err_q,   err_d;
    logic [WORD-1:0] rdata0_q, rdata0_d;
    logic [WORD-1:0] rdata1_q, rdata1_d;
    logic            busy_q,  busy_d;

    logic            acc_we;
    logic            acc_bad;
    logic [WORD-1:0] acc_addr;
    logic [WORD-1:0] acc_wdata;
    logic [WORD-1:0] resp_data;

    // Misaligned or beyond-the-end byte addresses are rejected without touching memory
    function automatic logic addr_bad(input logic [WORD-1:0] a);
        return (a[OFFS-1:0] != OFFS'(0)) || ((a >> OFFS) >= WORD'(SIZE));
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and arbitration (prio breaks ties only)
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        if (m0.req && m1.req) begin
            grant = prio_q;
        end else begin
            grant = m1.req;
        end
        unique case (state_q)
            IDLE:    if (m0.req || m1.req) state_d = ACC;
            ACC:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Winner's request fields, muxed for acceptance
    always_comb begin
        acc_we    = grant ? m1.we    : m0.we;
        acc_addr  = grant ? m1.addr  : m0.addr;
        acc_wdata = grant ? m1.wdata : m0.wdata;
        acc_bad   = addr_bad(acc_addr);
    end

    // Output/datapath next values, computed from current state and next state
    always_comb begin
        prio_d    = prio_q;
        sel_d     = sel_q;
        we_d      = we_q;
        bad_d     = bad_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        drive_d   = 1'b0;
        ack_d     = 2'b00;
        err_d     = 2'b00;
        rdata0_d  = '0;
        rdata1_d  = '0;
        busy_d    = (state_d != IDLE);
        resp_data = '0;

        unique case (state_q)
            IDLE: begin
                if (state_d == ACC) begin
                    sel_d   = grant;
                    we_d    = acc_we;
                    bad_d   = acc_bad;
                    addr_d  = acc_addr;
                    wdata_d = acc_wdata;
                    rd_d    = !acc_bad && !acc_we;
                    wr_d    = !acc_bad &&  acc_we;
                    drive_d = !acc_bad &&  acc_we;
                end
            end
            ACC: begin
                // Memory read path settles within ACC; capture at the closing edge
                resp_data    = (!we_q && !bad_q) ? mem_data : '0;
                ack_d[sel_q] = 1'b1;
                err_d[sel_q] = bad_q;
                if (sel_q) begin
                    rdata1_d = resp_data;
                end else begin
                    rdata0_d = resp_data;
                end
            end
            RESP: begin
                prio_d = ~sel_q;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers; reset releases the bus and drops enables at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q   <= 1'b0;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            bad_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            drive_q  <= 1'b0;
            ack_q    <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            bad_q    <= bad_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            drive_q  <= drive_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    // Port mapping of registered outputs
    assign MemRead  = rd_q;
    assign MemWrite = wr_q;
    assign mem_addr = addr_q;
    assign mem_data = drive_q ? wdata_q : 'z;
    assign busy     = busy_q;
    assign m0.ack   = ack_q[0];
    assign m0.err   = err_q[0];
    assign m0.rdata = rdata0_q;
    assign m1.ack   = ack_q[1];
    assign m1.err   = err_q[1];
    assign m1.rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, scoreboard of responses, corner sequences.
module tb_dmem_arbiter;

    localparam int unsigned WORD = 64;
    localparam int unsigned SIZE = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WORD(WORD)) m0_if ();
    dmem_arbiter_if #(.WORD(WORD)) m1_if ();

    logic            mem_read;
    logic            mem_write;
    logic [WORD-1:0] mem_addr;
    wire  [WORD-1:0] mem_data;
    logic            busy;

    dmem_arbiter #(.WORD(WORD), .SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .MemRead  (mem_read),
        .MemWrite (mem_write),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy)
    );

    // Data memory model: combinational read, write on the edge ending ACC
    logic [WORD-1:0] mem [SIZE];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[12:3]] <= mem_data;
    end
    assign mem_data = mem_read ? mem[mem_addr[12:3]] : 'z;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected responses, in service order
    typedef struct packed {
        logic        port;
        logic        err;
        logic [63:0] rdata;
    } resp_t;

    resp_t sb_q[$];
    resp_t sb_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read && mem_write) check("rd_wr_overlap", 64'(1), 64'(0));
            if (m0_if.ack && m1_if.ack) check("dual_ack", 64'(1), 64'(0));
            if (m0_if.ack || m1_if.ack) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 64'(1), 64'(0));
                end else begin
                    sb_e = sb_q.pop_front();
                    check("ack_port", 64'(m1_if.ack), 64'(sb_e.port));
                    if (m1_if.ack) begin
                        check("m1_err", 64'(m1_if.err), 64'(sb_e.err));
                        check("m1_rdata", m1_if.rdata, sb_e.rdata);
                        check("m0_quiet", {m0_if.rdata[61:0], m0_if.err, m0_if.ack}, 64'(0));
                    end else begin
                        check("m0_err", 64'(m0_if.err), 64'(sb_e.err));
                        check("m0_rdata", m0_if.rdata, sb_e.rdata);
                        check("m1_quiet", {m1_if.rdata[61:0], m1_if.err, m1_if.ack}, 64'(0));
                    end
                end
            end
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic drive_port(input logic port, input logic req, input logic we,
                              input logic [63:0] addr, input logic [63:0] wdata);
        if (port) begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
        end else begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
        end
    endtask

    // Single transaction from IDLE: checks ACC signals one cycle after accept, ack the cycle after
    task automatic do_txn(input vec_t v);
        logic ack_seen;
        @(negedge clk);
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        sb_q.push_back('{port: v.port, err: v.exp_err, rdata: v.exp_rdata});
        @(posedge clk); #1;
        check("acc_busy", 64'(busy), 64'(1));
        check("acc_memread", 64'(mem_read), 64'(!v.we && !v.exp_err));
        check("acc_memwrite", 64'(mem_write), 64'(v.we && !v.exp_err));
        check("acc_addr", mem_addr, v.addr);
        drive_port(v.port, 1'b0, 1'b0, 64'(0), 64'(0));
        @(posedge clk); #1;
        ack_seen = v.port ? m1_if.ack : m0_if.ack;
        check("ack_latency", 64'(ack_seen), 64'(1));
        check("resp_enables", {62'(0), mem_read, mem_write}, 64'(0));
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {59'(0), busy, mem_read, mem_write, m0_if.ack, m1_if.ack}, 64'(0));
        check("rst_flags_addr", mem_addr | 64'(m0_if.err) | 64'(m1_if.err), 64'(0));
        check("rst_rdata", m0_if.rdata | m1_if.rdata, 64'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    int n_ack;
    int last_c;
    int first_c;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 64'h10,   64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 1'b0, 64'h10,   64'h0,    1'b0, 64'h0000_0000_DEAD_BEEF};  // m0 alone while prio=m1
        vecs[2]  = '{1'b1, 1'b0, 64'h13,   64'h0,    1'b1, 64'h0};
        vecs[3]  = '{1'b1, 1'b0, 64'h2000, 64'h0,    1'b1, 64'h0};
        vecs[4]  = '{1'b1, 1'b1, 64'h18,   64'hAAAA, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, 1'b1, 64'h0,    64'h1111, 1'b0, 64'h0};
        vecs[6]  = '{1'b1, 1'b1, 64'h8,    64'h2222, 1'b0, 64'h0};
        vecs[7]  = '{1'b1, 1'b1, 64'h1FF8, 64'h5A5A, 1'b0, 64'h0};
        vecs[8]  = '{1'b0, 1'b0, 64'h1FF8, 64'h0,    1'b0, 64'h5A5A};
        vecs[9]  = '{1'b0, 1'b1, 64'h4,    64'hFFFF, 1'b1, 64'h0};
        vecs[10] = '{1'b0, 1'b0, 64'h10,   64'h0,    1'b0, 64'h0000_0000_DEAD_BEEF};
        vecs[11] = '{1'b1, 1'b0, 64'h18,   64'h0,    1'b0, 64'hAAAA};

        drive_port(1'b0, 1'b0, 1'b0, 64'(0), 64'(0));
        drive_port(1'b1, 1'b0, 1'b0, 64'(0), 64'(0));
        #1;
        pulse_reset();

        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i]);
        end

        // Both requesting continuously from reset: strict alternation every 3 cycles
        pulse_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{port: 1'(i % 2), err: 1'b0,
                             rdata: (i % 2 == 0) ? 64'h1111 : 64'h2222});
        end
        drive_port(1'b0, 1'b1, 1'b0, 64'h0, 64'h0);
        drive_port(1'b1, 1'b1, 1'b0, 64'h8, 64'h0);
        n_ack   = 0;
        last_c  = -1;
        first_c = -1;
        for (int c = 0; c < 40 && n_ack < 6; c++) begin
            @(negedge clk);
            if (m0_if.ack || m1_if.ack) begin
                n_ack++;
                if (last_c >= 0) check("ack_spacing", 64'(c - last_c), 64'(3));
                else first_c = c;
                last_c = c;
            end
        end
        drive_port(1'b0, 1'b0, 1'b0, 64'(0), 64'(0));
        drive_port(1'b1, 1'b0, 1'b0, 64'(0), 64'(0));
        check("alt_count", 64'(n_ack), 64'(6));
        check("alt_first_latency", 64'(first_c), 64'(1));
        repeat (3) @(posedge clk);

        // Reset during a write ACC: enable drops immediately, no write, no ack
        @(negedge clk);
        drive_port(1'b1, 1'b1, 1'b1, 64'h18, 64'h1234);
        @(posedge clk); #1;
        check("abort_memwrite_before", 64'(mem_write), 64'(1));
        drive_port(1'b1, 1'b0, 1'b0, 64'(0), 64'(0));
        #2;
        rst = 1'b1;
        #1;
        check("abort_memwrite_after", 64'(mem_write), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        do_txn(vecs[11]);

        repeat (4) @(posedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory. It shares `data_mem` between the pipeline MEM stage (port m0) and the debug/program loader (port m1). Each access runs a fixed three-cycle sequence: accept, memory access, response. The block drives `MemRead`/`MemWrite`/`addr` and owns the write side of the bidirectional `data` bus. Requesters see a level `req`, a one-cycle `ack` pulse, registered read data and an error flag.

## Interface
- `WORD`, 64: data/address width; must equal the memory's `` `WORD ``.
- `SIZE`, 1024: memory depth in words; addresses with `addr/8 >= SIZE` are out of range.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mN_req` in 1 (N = 0, 1): access request, level, held until `mN_ack`.
- `mN_we` in 1: 1 = write, 0 = read; sampled with `req` at acceptance.
- `mN_addr` in WORD: byte address; must be 8-byte aligned.
- `mN_wdata` in WORD: write data; sampled at acceptance.
- `mN_ack` out 1: one-cycle completion pulse.
- `mN_err` out 1: valid with `ack`; 1 = misaligned or out-of-range access, not performed.
- `mN_rdata` out WORD: read data, valid with `ack` for reads; 0 for writes and errors.
- `MemRead` out 1: memory read enable.
- `MemWrite` out 1: memory write enable.
- `mem_addr` out WORD: memory byte address.
- `mem_data` inout WORD: memory data bus; driven only during a write access, else `'bz`.
- `busy` out 1: 1 whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE → ACC when any `req` is high at the edge. Arbitrate, then latch winner id, `we`, `addr`, `wdata` and error flag into registers.
  - ACC → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Arbitration:
  - One requester high: it wins.
  - Both high: the winner is the priority pointer `prio`.
  - After every RESP, including error responses, `prio` becomes the requester not just served.
  - Reset sets `prio` to m0.
- Error check at acceptance: `addr[2:0] != 0` or `addr/8 >= SIZE` sets the error flag. An error access runs IDLE→ACC→RESP with `MemRead`/`MemWrite` held at 0 during ACC and responds `err=1`, `rdata=0`.
- ACC, read:
  - `MemRead=1`, `MemWrite=0`, `mem_addr` = latched address, `mem_data` released.
  - `mem_data` is captured into the rdata register at the edge ending ACC.
- ACC, write:
  - `MemWrite=1`, `MemRead=0`, `mem_data` driven with latched wdata.
  - The memory commits the write at the edge ending ACC.
- `MemRead` and `MemWrite` are never 1 together; both are 0 outside ACC.
- RESP: `ack=1` to the served requester only; `err`/`rdata` from registers. The other requester's `ack`/`err`/`rdata` stay 0.
- A requester still asserting `req` at the edge ending RESP starts a new transaction in IDLE; it competes under the updated `prio`.
- `req` changes during ACC/RESP are ignored; inputs are sampled only in IDLE.

## Timing
- Reset values: state IDLE, `prio`=m0, `MemRead`=`MemWrite`=0, `mem_addr`=0, `mem_data`=`'bz`, all `ack`/`err`=0, all `rdata`=0, `busy`=0.
- `rst` asserted mid-ACC drops `MemWrite`/`MemRead` and releases the bus immediately (asynchronous), so no memory write occurs. The transaction is lost with no `ack`; the requester re-issues after reset.
- Latency: `req` sampled at edge k, ACC is cycle k+1, `ack` is cycle k+2. Minimum spacing between accepts is 3 cycles.
- Throughput: one access per 3 cycles. With both requesters continuously high, accesses alternate m0, m1, m0, …
- All outputs are registered or decoded from state registers only; no combinational path from `mN_*` inputs to any output.
- The memory read path is combinational within ACC; `mem_data` must settle within that cycle.

## Test plan
- Reset check: assert `rst` for 2 cycles → all outputs at reset values, `mem_data` high-Z, `busy`=0.
- m0 writes `0x00000000DEADBEEF` to 0x10, then m0 reads 0x10 → write `ack` at cycle +2 with `err`=0 and `rdata`=0; read `ack` returns 0xDEADBEEF. In ACC, `MemWrite`=1 and `mem_addr`=0x10.
- Both `req` high from reset for 6 accesses, m0 at 0x0, m1 at 0x8 → served order m0, m1, m0, m1, m0, m1; `ack` pulses alternate every 3 cycles; never two acks in one cycle.
- m1 reads 0x13 (misaligned), then 0x2000 (word 1024, out of range) → both `ack` with `err`=1, `rdata`=0; `MemRead`/`MemWrite` stay 0 throughout. Memory contents unchanged.
- m1 writes 0x1234 to 0x18 with `rst` pulsed during ACC → no `ack`; `MemWrite` falls with `rst`; a later read of 0x18 returns the prior value.
- m0 `req` only (single requester) with `prio`=m1 → m0 granted immediately; no idle wait for m1.
